c8_vector_loader: RTL
=====================

# c8_vector_loader

Byte-serial front end for the c8 combinational core. It accepts a frame of four bytes over a valid/ready stream and assembles them into the core's 28-bit input vector (a..h, i..p, u..b0, q, r, s, c0). It buffers up to two complete vectors in a 2-entry output FIFO and presents them to the core stage through a valid/ready handshake. It also checks frame framing and the reserved bits, and drops bad frames.

## Interface
Parameters:
- FIFO_DEPTH, 2: output vector FIFO entries. The only supported value is 2.
- CNT_W, 16: width of the accepted-frame counter.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  8  frame byte
- in_sof  in  1  marks byte 0 of a frame
- in_valid  in  1  byte offered
- in_ready  out  1  byte accepted when in_valid & in_ready
- in_par  in  1  even-parity bit for in_data; port present only with C8_LOADER_PARITY_EN
- vec_data  out  28  assembled vector: [7:0]=a..h (a=bit0), [15:8]=i..p, [23:16]=u,v,w,x,y,z,a0,b0, [24]=q, [25]=r, [26]=s, [27]=c0
- vec_valid  out  1  FIFO head valid
- vec_ready  in  1  downstream takes the head when vec_valid & vec_ready
- frame_err  out  1  one-cycle pulse when a frame is dropped
- frame_cnt  out  CNT_W  count of frames pushed into the FIFO; wraps modulo 2^CNT_W

## Operation
- FSM states:
  - IDLE: idx=0, waiting for a byte with in_sof=1. Bytes with in_sof=0 are accepted and discarded, with a frame_err pulse.
  - COLLECT: idx=1..3.
  - DROP: not used as a state. A dropped frame returns directly to IDLE.
- On an accepted byte with in_sof=1 in any state:
  - byte is latched as byte 0; idx goes to 1.
  - If the FSM was in COLLECT, the partial frame is discarded and frame_err pulses.
- In COLLECT, an accepted byte with in_sof=0 is stored at idx and idx increments.
- When byte 3 is accepted:
  - in_data[7:4] must be 0000. If not, the frame is dropped, frame_err pulses, and the FSM goes to IDLE.
  - Otherwise {byte3[3:0], byte2, byte1, byte0} is pushed to the FIFO, frame_cnt increments, and the FSM goes to IDLE.
- in_ready = 0 only when idx==3 and the FIFO is full. Otherwise in_ready = 1.
- A push never happens into a full FIFO. A pop in the same cycle does not free the slot for that cycle's byte 3; this keeps in_ready free of any vec_ready combinational path.
- FIFO: 2 entries, in order. Push and pop in the same cycle are legal when the FIFO is not full. vec_data holds the head and is stable while vec_valid & ~vec_ready.

## Timing
- Reset values:
  - in_ready=1
  - vec_valid=0
  - vec_data=0
  - frame_err=0
  - frame_cnt=0
  - FSM=IDLE, idx=0, FIFO empty
- Latency: byte 3 accepted in cycle N gives vec_valid=1 in cycle N+1 (FIFO was empty).
- frame_err is registered and asserts in the cycle after the offending byte is accepted.
- Reset asserted mid-frame or with FIFO entries pending discards everything. No frame_err pulse is generated for reset.
- Maximum sustained throughput is one frame per 4 cycles, with vec_ready held high.

## Configuration
- C8_LOADER_PARITY_EN defined:
  - in_par port exists.
  - Every accepted byte is checked for ^{in_data,in_par}==0.
  - A mismatch on any byte drops the current frame with a frame_err pulse. If the failing byte had in_sof=1, it does not start a frame.
- C8_LOADER_PARITY_EN undefined: no in_par port and no parity logic. Behaviour is otherwise identical.

## Structure
- Shared package c8_pkg holds:
  - VEC_W=28
  - field offset constants (A_LO=0, I_LO=8, U_LO=16, Q_BIT=24, R_BIT=25, S_BIT=26, C0_BIT=27)
  - FSM state enum
  - BYTES_PER_FRAME=4
- One sub-module, c8_vec_fifo: 2-entry synchronous FIFO with full/empty flags. The top level holds the FSM, assembly registers, checks and counter.

## Test plan
- Frame 0x01,0x80,0xFF,0x09 with sof on byte 0, vec_ready=1:
  - vec_data=0x9FF8001 one cycle after byte 3.
  - frame_cnt=1, frame_err stays 0.
- Three back-to-back frames with vec_ready=0:
  - two frames fill the FIFO.
  - in_ready=0 while byte 3 of the third frame is offered.
  - After raising vec_ready: vectors come out in order, all three delivered, frame_cnt=3.
- sof=1 at idx=2 → frame_err pulse; the new frame assembles correctly from that byte.
- Byte 3 = 0x19 → frame dropped, frame_err pulse, no vec_valid, frame_cnt unchanged.
- rst asserted after byte 1 and then released; clean frame sent → only the clean vector appears, frame_cnt=1.
- (C8_LOADER_PARITY_EN) byte 2 = 0x03 with in_par=1 → frame dropped, frame_err pulse.

Source files
------------

// File: rtl/c8_pkg.sv
// Shared constants, FSM state type and vector packing helper for the c8 vector loader.
package c8_pkg;

    localparam int VEC_W           = 28;
    localparam int BYTES_PER_FRAME = 4;

    localparam int A_LO   = 0;
    localparam int I_LO   = 8;
    localparam int U_LO   = 16;
    localparam int Q_BIT  = 24;
    localparam int R_BIT  = 25;
    localparam int S_BIT  = 26;
    localparam int C0_BIT = 27;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_t;

    // The low nibble of byte 3 carries q, r, s, c0 in that bit order.
    function automatic logic [VEC_W-1:0] pack_vec(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [3:0] nib
    );
        logic [VEC_W-1:0] v;
        v              = '0;
        v[A_LO +: 8]   = b0;
        v[I_LO +: 8]   = b1;
        v[U_LO +: 8]   = b2;
        v[Q_BIT]       = nib[0];
        v[R_BIT]       = nib[1];
        v[S_BIT]       = nib[2];
        v[C0_BIT]      = nib[3];
        return v;
    endfunction

endpackage

// File: rtl/c8_vec_fifo.sv
// Small synchronous FIFO holding assembled vectors; head is presented on rdata.
module c8_vec_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/c8_vector_loader.sv
// Byte-serial frame assembler feeding the c8 core through a 2-entry vector FIFO.
// Optional even-parity checking on every byte is enabled by defining C8_LOADER_PARITY_EN.
module c8_vector_loader
    import c8_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_sof,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef C8_LOADER_PARITY_EN
    input  logic             in_par,
`endif
    output logic [VEC_W-1:0] vec_data,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_FRAME - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      asm_q, asm_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             accept;
    logic             par_ok;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [VEC_W-1:0] push_vec;

`ifdef C8_LOADER_PARITY_EN
    assign par_ok = ~^{in_data, in_par};
`else
    assign par_ok = 1'b1;
`endif

    // Stalling only on the final byte keeps in_ready free of any vec_ready path.
    assign in_ready  = ~((idx_q == LAST_IDX) & fifo_full);
    assign accept    = in_valid & in_ready;
    assign push_vec  = pack_vec(asm_q[7:0], asm_q[15:8], asm_q[23:16], in_data[3:0]);
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign vec_valid = ~fifo_empty;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        push        = 1'b0;
        if (accept) begin
            if (!par_ok) begin
                state_d     = ST_IDLE;
                idx_d       = '0;
                frame_err_d = 1'b1;
            end else if (in_sof) begin
                asm_d[7:0]  = in_data;
                idx_d       = 2'd1;
                state_d     = ST_COLLECT;
                frame_err_d = (state_q == ST_COLLECT);
            end else if (state_q == ST_IDLE) begin
                frame_err_d = 1'b1;
            end else if (idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                if (in_data[7:4] != 4'h0) begin
                    frame_err_d = 1'b1;
                end else begin
                    push        = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end else begin
                asm_d[{idx_q, 3'b000} +: 8] = in_data;
                idx_d                       = idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            asm_q       <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    c8_vec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (VEC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_vec),
        .pop   (vec_ready),
        .rdata (vec_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
